// File: rtl/e_stage_mdu.sv
// rtl/e_stage_mdu.sv - execute-stage multiply/divide unit owning the HI/LO registers
//
// Purpose: accepts one MDU op per idle cycle, computes the 64-bit result
// immediately into a pending register pair, and commits it to the
// architectural HI/LO after a fixed busy period. This models the
// multi-cycle latency seen by the decode-stage hazard logic.
//
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7-10).
//
// Parameters:
//   MUL_CYCLES  busy cycles for mult-class ops (1-15)
//   DIV_CYCLES  busy cycles for div-class ops (1-15)
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   start     one-cycle strobe, execute-stage instruction is an MDU op
//   op        operation code (see localparams below)
//   a, b      rs / rt operands
//   rd_sel    0 reads LO, 1 reads HI on hilo_out
//   busy      op in flight, or multi-cycle op being accepted this cycle
//   hilo_out  combinational read of architectural HI or LO
module e_stage_mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hilo_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    logic [31:0] hi, lo, hi_p, lo_p;
    logic [3:0]  count;
    // Cleared for divide-by-zero so the busy period runs but nothing commits.
    logic        wr_pend;

    logic        multi_op;
    logic signed [63:0] sa, sb;
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    always_comb begin
        multi_op = (op == OP_MULT) || (op == OP_MULTU) ||
                   (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        multi_op = multi_op || (op == OP_MADD) || (op == OP_MADDU) ||
                   (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    end

    assign busy     = (count != 4'd0) || (start && multi_op);
    assign hilo_out = rd_sel ? hi : lo;

    assign sa     = {{32{a[31]}}, a};
    assign sb     = {{32{b[31]}}, b};
    assign prod_s = sa * sb;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divisor 0 is replaced by 1 to keep the operator defined (result is
    // discarded anyway). 0x80000000 / -1 is steered to a divisor of 1 as
    // well, which yields exactly the required LO=0x80000000, HI=0.
    always_comb begin
        div_b = b;
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            div_b = 32'd1;
    end

    assign quo_s = $signed(a) / $signed(div_b);
    assign rem_s = $signed(a) % $signed(div_b);
    assign quo_u = a / div_b;
    assign rem_u = a % div_b;

`ifdef MDU_MADD_EN
    logic [63:0] acc_prod, acc_sum;
    always_comb begin
        acc_prod = ((op == OP_MADD) || (op == OP_MSUB)) ? prod_s : prod_u;
        if ((op == OP_MSUB) || (op == OP_MSUBU))
            acc_sum = {hi, lo} - acc_prod;
        else
            acc_sum = {hi, lo} + acc_prod;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_p    <= 32'd0;
            lo_p    <= 32'd0;
            count   <= 4'd0;
            wr_pend <= 1'b0;
        end else if (count != 4'd0) begin
            // Starts arriving here are stalls that decode failed to honour.
            count <= count - 4'd1;
            if (count == 4'd1 && wr_pend) begin
                hi <= hi_p;
                lo <= lo_p;
            end
        end else if (start) begin
            case (op)
                OP_MULT: begin
                    {hi_p, lo_p} <= prod_s;
                    count        <= MUL_CNT;
                    wr_pend      <= 1'b1;
                end
                OP_MULTU: begin
                    {hi_p, lo_p} <= prod_u;
                    count        <= MUL_CNT;
                    wr_pend      <= 1'b1;
                end
                OP_DIV: begin
                    lo_p    <= quo_s;
                    hi_p    <= rem_s;
                    count   <= DIV_CNT;
                    wr_pend <= (b != 32'd0);
                end
                OP_DIVU: begin
                    lo_p    <= quo_u;
                    hi_p    <= rem_u;
                    count   <= DIV_CNT;
                    wr_pend <= (b != 32'd0);
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                    {hi_p, lo_p} <= acc_sum;
                    count        <= MUL_CNT;
                    wr_pend      <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_e_stage_mdu.sv
// tb/tb_e_stage_mdu.sv - scoreboard testbench for e_stage_mdu
module tb_e_stage_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] hilo_out;

    int passed = 0;
    int total  = 0;

    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_stage_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .rd_sel(rd_sel), .busy(busy), .hilo_out(hilo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        rd_sel = 1'b1; #1;
        check({tag, "_hi"}, hilo_out, eh);
        rd_sel = 1'b0; #1;
        check({tag, "_lo"}, hilo_out, el);
    endtask

    // Drive one op, measure its busy window, then pop and compare the result.
    // intr=1 injects an mtlo start two cycles into the busy window.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int lat,
                          input logic [31:0] eh, input logic [31:0] el, input bit intr);
        logic [63:0] exp;
        int n;
        sb_q.push_back({eh, el});
        start = 1'b1; op = o; a = x; b = y;
        #1;
        check({tag, "_busy_accept"}, {31'd0, busy}, {31'd0, lat != 0});
        tick();
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            if (n == 0) begin
                rd_sel = 1'b0; #1;
                check({tag, "_pending_hidden"}, hilo_out, m_lo);
            end
            if (intr && n == 2) begin
                start = 1'b1; op = 4'd6; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; op = 4'd0;
            end
            n++;
            tick();
        end
        start = 1'b0; op = 4'd0;
        check({tag, "_latency"}, n, lat);
        exp = sb_q.pop_front();
        check_hilo(tag, exp[63:32], exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; rd_sel = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check_hilo("reset", 32'd0, 32'd0);

        run_op("mult",   4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("multu",  4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("div",    4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu0",  4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu",   4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
        run_op("mthi",   4'd5, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'd14, 1'b0);
        run_op("intr",   4'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1);
        run_op("op12",   4'd12, 32'h5555_5555, 32'd3, 0, 32'd0, 32'd12, 1'b0);

        // Reset three cycles into a divide discards the pending result.
        start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd3;
        tick();
        start = 1'b0; op = 4'd0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_hilo("rst_mid", 32'd0, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check_hilo("rst_mid_late", 32'd0, 32'd0);

        // Reset wins over a same-edge start.
        reset = 1'b1; start = 1'b1; op = 4'd5; a = 32'h0000_0055;
        tick();
        reset = 1'b0; start = 1'b0; op = 4'd0;
        check_hilo("rst_start", 32'd0, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        run_op("mtlo", 4'd6, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_MADD_EN
        run_op("maddu", 4'd8, 32'd1, 32'd1, 5, 32'd1, 32'd0, 1'b0);
        run_op("msub",  4'd9, 32'd2, 32'd3, 5, 32'd0, 32'hFFFF_FFFA, 1'b0);
`else
        run_op("maddu", 4'd8, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("msub",  4'd9, 32'd2, 32'd3, 0, 32'd0, 32'hFFFF_FFFF, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
